// File: rtl/prbs_pkg.sv
// Shared PRBS6 (x^6+x^5+1, xnor form) definitions used by the generator and checker.
package prbs_pkg;

  localparam int PRBS6_TAP_A = 5;
  localparam int PRBS6_TAP_B = 6;

  // All-ones is the xnor lockup state; a real sequence never contains it.
  localparam logic [6:1] PRBS6_LOCKUP = 6'b111111;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } chk_state_e;

  // Next sequence bit given the last six bits, r[1] being the newest.
  function automatic logic prbs6_pred(input logic [6:1] r);
    return r[PRBS6_TAP_A] ~^ r[PRBS6_TAP_B];
  endfunction

endpackage

// File: rtl/prbs6_checker_if.sv
// Serial PRBS checker bus: received bit stream in, lock/error status out.
// Optional err_sticky present when PRBS_STICKY_ERR_EN is defined.
interface prbs6_checker_if #(parameter int CNT_W = 16);

  logic             din;
  logic             din_valid;
  logic             clr;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] bit_cnt;
`ifdef PRBS_STICKY_ERR_EN
  logic             err_sticky;
`endif

  modport master (
    output din, din_valid, clr,
`ifdef PRBS_STICKY_ERR_EN
    input  err_sticky,
`endif
    input  locked, err, err_cnt, bit_cnt
  );

  modport slave (
    input  din, din_valid, clr,
`ifdef PRBS_STICKY_ERR_EN
    output err_sticky,
`endif
    output locked, err, err_cnt, bit_cnt
  );

endinterface

// File: rtl/prbs6_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module prbs6_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (inc && (cnt != '1)) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/prbs6_checker.sv
// Self-synchronising PRBS6 xnor checker with flywheel, saturating counters and
// loss-of-lock detection. Define PRBS_STICKY_ERR_EN to add the err_sticky output.
module prbs6_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT = 12,
  parameter int WINDOW   = 64,
  parameter int LOSS_THR = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  prbs6_checker_if.slave   bus
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int EW = $clog2(LOSS_THR + 1);
  localparam logic [MW-1:0] LOCK_V   = MW'(LOCK_CNT);
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);
  localparam logic [EW-1:0] THR_LAST = EW'(LOSS_THR - 1);

  chk_state_e    state;
  logic [6:1]    ref_q;
  logic [MW-1:0] match_cnt;
  logic [WW-1:0] win_cnt;
  logic [EW-1:0] win_err;
  logic          err_q;
  logic          pred, mis, chk_bit, err_bit;

  assign pred    = prbs6_pred(ref_q);
  assign mis     = bus.din ^ pred;
  assign chk_bit = bus.din_valid && (state == LOCKED);
  assign err_bit = chk_bit && mis;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SEARCH;
      ref_q     <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= err_bit;
      if (bus.din_valid) begin
        if (state == SEARCH) begin
          ref_q <= {ref_q[5:1], bus.din};
          if (mis || (ref_q == PRBS6_LOCKUP)) begin
            match_cnt <= '0;
          end else begin
            match_cnt <= match_cnt + 1'b1;
            if (match_cnt + 1'b1 == LOCK_V) begin
              state   <= LOCKED;
              win_cnt <= '0;
              win_err <= '0;
            end
          end
        end else begin
          // Flywheel on our own prediction so a channel error stays a single error.
          ref_q <= {ref_q[5:1], pred};
          if (mis && (win_err == THR_LAST)) begin
            state     <= SEARCH;
            match_cnt <= '0;
          end else if (win_cnt == WIN_LAST) begin
            win_cnt <= '0;
            win_err <= '0;
          end else begin
            win_cnt <= win_cnt + 1'b1;
            win_err <= win_err + EW'(mis);
          end
        end
      end
    end
  end

  prbs6_sat_cnt #(.CNT_W(CNT_W)) u_bit_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (chk_bit),
    .clr     (bus.clr),
    .cnt     (bus.bit_cnt)
  );

  prbs6_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (err_bit),
    .clr     (bus.clr),
    .cnt     (bus.err_cnt)
  );

  assign bus.locked = (state == LOCKED);
  assign bus.err    = err_q;

`ifdef PRBS_STICKY_ERR_EN
  logic sticky_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     sticky_q <= 1'b0;
    else if (err_bit) sticky_q <= 1'b1;
    else if (bus.clr) sticky_q <= 1'b0;
  end
  assign bus.err_sticky = sticky_q;
`endif

endmodule
